// File: rtl/mem_arbiter.sv
// Two-master (I/D) to one-slave memory arbiter with a latched downstream command.
// Optional round-robin grant selected by MEM_ARBITER_ROUND_ROBIN_EN; fixed D-over-I priority otherwise.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_read,
  input  logic [ADDR_W-1:0]   imem_address,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [ADDR_W-1:0]   dmem_address,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_byte_enable,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                cmd_rd_q, cmd_rd_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W/8-1:0] cmd_be_q, cmd_be_d;
  logic                i_req, d_req, grant_d;
  logic                serving;

  assign i_req = imem_read;
  assign d_req = dmem_read | dmem_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_d_q = 1 means D was granted last, so I wins the next tie.
  logic last_d_q;
  assign grant_d = d_req & (~i_req | ~last_d_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              last_d_q <= 1'b1;
    else if (state_q == IDLE && (i_req || d_req)) last_d_q <= grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = SERVE_D;
          cmd_rd_d    = dmem_read;
          cmd_wr_d    = dmem_write;
          cmd_addr_d  = dmem_address;
          cmd_wdata_d = dmem_wdata;
          cmd_be_d    = dmem_read ? '1 : dmem_byte_enable;
        end else if (i_req) begin
          state_d     = SERVE_I;
          cmd_rd_d    = 1'b1;
          cmd_wr_d    = 1'b0;
          cmd_addr_d  = imem_address;
          cmd_wdata_d = '0;
          cmd_be_d    = '1;
        end
      end
      SERVE_I, SERVE_D: if (mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
    end
  end

  // Downstream command is masked in IDLE so stale register contents never leak out.
  assign serving         = (state_q != IDLE);
  assign mem_read        = serving & cmd_rd_q;
  assign mem_write       = serving & cmd_wr_q;
  assign mem_address     = serving ? cmd_addr_q  : '0;
  assign mem_wdata       = serving ? cmd_wdata_q : '0;
  assign mem_byte_enable = serving ? cmd_be_q    : '0;

  assign imem_resp  = (state_q == SERVE_I) & mem_resp;
  assign dmem_resp  = (state_q == SERVE_D) & mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : '0;
  assign dmem_rdata = (dmem_resp & cmd_rd_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_read;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_rdata;
  logic          imem_resp;
  logic          dmem_read, dmem_write;
  logic [AW-1:0] dmem_address;
  logic [DW-1:0] dmem_wdata;
  logic [BW-1:0] dmem_byte_enable;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_resp;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_byte_enable;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp;

  logic [AW+3*DW+BW+3:0] all_outs;
  assign all_outs = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
                     imem_resp, imem_rdata, dmem_resp, dmem_rdata};

  int checks = 0;
  int errors = 0;
  bit m_last_d;  // model: D was granted last

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    imem_read = 0; imem_address = '0;
    dmem_read = 0; dmem_write = 0; dmem_address = '0; dmem_wdata = '0; dmem_byte_enable = '0;
    mem_rdata = '0; mem_resp = 0;
  endtask

  task automatic apply_reset;
    rst = 1; idle_inputs(); tick(); tick(); rst = 0; m_last_d = 1;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs(); tick();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
    rst = 0; m_last_d = 1;
    dmem_read = 1; dmem_address = 32'h3000;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h3000) begin
      errors++; $display("FAIL reset_pre_serve_d: rd=%b addr=%h want 1/3000", mem_read, mem_address);
    end
    #2 rst = 1; mem_resp = 1; mem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_midtx_outputs: got %h want 0", all_outs); end
    tick();
    rst = 0; m_last_d = 1; idle_inputs();
    imem_read = 1; imem_address = 32'h100;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h100 || mem_byte_enable !== 4'hF) begin
      errors++; $display("FAIL reset_then_i: rd=%b wr=%b addr=%h be=%h want 1/0/100/f",
                         mem_read, mem_write, mem_address, mem_byte_enable);
    end
    m_last_d = 0;
    mem_resp = 1; #1;
    checks++;
    if (imem_resp !== 1'b1) begin errors++; $display("FAIL reset_then_i_resp: got %b want 1", imem_resp); end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_single_i;
    imem_read = 1; imem_address = 32'h40;
    tick();
    m_last_d = 0;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h40 || imem_resp !== 1'b0) begin
      errors++; $display("FAIL single_i_cmd: rd=%b addr=%h resp=%b want 1/40/0", mem_read, mem_address, imem_resp);
    end
    tick();
    checks++;
    if (imem_resp !== 1'b0 || mem_read !== 1'b1) begin
      errors++; $display("FAIL single_i_wait: resp=%b rd=%b want 0/1", imem_resp, mem_read);
    end
    tick();
    mem_resp = 1; mem_rdata = 32'hDEADBEEF; #1;
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'hDEADBEEF || dmem_resp !== 1'b0) begin
      errors++; $display("FAIL single_i_resp: resp=%b rdata=%h dresp=%b want 1/deadbeef/0",
                         imem_resp, imem_rdata, dmem_resp);
    end
    tick();
    mem_resp = 0; imem_read = 0; #1;
    checks++;
    if (imem_resp !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL single_i_after: resp=%b rd=%b want 0/0", imem_resp, mem_read);
    end
    tick();
  endtask

  task automatic test_d_write;
    idle_inputs();
    dmem_write = 1; dmem_address = 32'h2002; dmem_wdata = 32'h0000AB00; dmem_byte_enable = 4'hC;
    tick();
    m_last_d = 1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h2002 ||
          mem_wdata !== 32'h0000AB00 || mem_byte_enable !== 4'hC) begin
        errors++; $display("FAIL d_write_cmd[%0d]: wr=%b rd=%b addr=%h wd=%h be=%h want 1/0/2002/0000ab00/c",
                           k, mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable);
      end
      dmem_address = 32'hFFFF_0000 + k; dmem_wdata = 32'h1234_0000 + k; dmem_byte_enable = 4'h3;
      if (k == 1) tick(); else #1;
    end
    mem_resp = 1; mem_rdata = 32'h5A5A5A5A; #1;
    checks++;
    if (dmem_resp !== 1'b1 || dmem_rdata !== '0 || imem_resp !== 1'b0) begin
      errors++; $display("FAIL d_write_resp: resp=%b rdata=%h iresp=%b want 1/0/0", dmem_resp, dmem_rdata, imem_resp);
    end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_contention;
    bit first_d;
    imem_read = 1; imem_address = 32'h500;
    dmem_read = 1; dmem_address = 32'h600;
    first_d = !RR || !m_last_d;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== (first_d ? 32'h600 : 32'h500)) begin
      errors++; $display("FAIL contention_first: rd=%b addr=%h want 1/%h", mem_read, mem_address,
                         first_d ? 32'h600 : 32'h500);
    end
    mem_resp = 1; mem_rdata = 32'h0A0B0C0D; #1;
    checks++;
    if (dmem_resp !== first_d || imem_resp !== !first_d) begin
      errors++; $display("FAIL contention_first_resp: d=%b i=%b want %b/%b", dmem_resp, imem_resp, first_d, !first_d);
    end
    m_last_d = first_d;
    tick();
    mem_resp = 0;
    if (first_d) dmem_read = 0; else imem_read = 0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL contention_bubble: rd=%b wr=%b want 0/0", mem_read, mem_write);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== (first_d ? 32'h500 : 32'h600)) begin
      errors++; $display("FAIL contention_second: rd=%b addr=%h want 1/%h", mem_read, mem_address,
                         first_d ? 32'h500 : 32'h600);
    end
    mem_resp = 1; #1;
    checks++;
    if (dmem_resp !== !first_d || imem_resp !== first_d) begin
      errors++; $display("FAIL contention_second_resp: d=%b i=%b want %b/%b", dmem_resp, imem_resp, !first_d, first_d);
    end
    m_last_d = !first_d;
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_alternation;
    bit exp_d;
    apply_reset();
    imem_read = 1; imem_address = 32'h1000;
    dmem_read = 1; dmem_address = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      exp_d = !RR || !m_last_d;
      tick();
      checks++;
      if (mem_address !== (exp_d ? 32'h2000 : 32'h1000)) begin
        errors++; $display("FAIL alternate_grant[%0d]: addr=%h want %h", k, mem_address, exp_d ? 32'h2000 : 32'h1000);
      end
      mem_resp = 1; mem_rdata = 32'hC0DE_0000 + k; #1;
      checks++;
      if (dmem_resp !== exp_d || imem_resp !== !exp_d) begin
        errors++; $display("FAIL alternate_resp[%0d]: d=%b i=%b want %b/%b", k, dmem_resp, imem_resp, exp_d, !exp_d);
      end
      m_last_d = exp_d;
      tick();
      mem_resp = 0; #1;
      checks++;
      if (mem_read !== 1'b0) begin errors++; $display("FAIL alternate_bubble[%0d]: rd=%b want 0", k, mem_read); end
    end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_stray;
    idle_inputs(); tick();
    mem_resp = 1; mem_rdata = 32'hFFFF_FFFF; #1;
    checks++;
    if (imem_resp !== 1'b0 || dmem_resp !== 1'b0 || imem_rdata !== '0 || dmem_rdata !== '0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL stray_resp: i=%b d=%b ird=%h drd=%h rd=%b want all 0",
                         imem_resp, dmem_resp, imem_rdata, dmem_rdata, mem_read);
    end
    tick();
    mem_resp = 0; imem_read = 1; imem_address = 32'h77C;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h77C) begin
      errors++; $display("FAIL stray_then_i: rd=%b addr=%h want 1/77c", mem_read, mem_address);
    end
    mem_resp = 1; #1;
    checks++;
    if (imem_resp !== 1'b1) begin errors++; $display("FAIL stray_then_i_resp: got %b want 1", imem_resp); end
    m_last_d = 0;
    tick(); idle_inputs(); tick();
  endtask

  // Transaction-level model: owner of the downstream port (0 none, 1 I, 2 D) and its captured command.
  task automatic test_random;
    int busy = 0;
    int n_done = 0;
    bit e_rd, e_wr, pick_d, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [BW-1:0] e_be;
    bit op;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (busy != 0) begin
        if (mem_resp) begin
          if (busy == 1) imem_read = 0; else begin dmem_read = 0; dmem_write = 0; end
          busy = 0; n_done++;
        end
      end else if (imem_read || dmem_read || dmem_write) begin
        pick_d = (dmem_read || dmem_write) && (!imem_read || !RR || !m_last_d);
        m_last_d = pick_d;
        busy = pick_d ? 2 : 1;
        e_rd = pick_d ? dmem_read : 1'b1;
        e_wr = pick_d ? dmem_write : 1'b0;
        e_addr = pick_d ? dmem_address : imem_address;
        e_wd = dmem_wdata;
        e_be = (pick_d && dmem_write) ? dmem_byte_enable : '1;
      end
      if (!imem_read && $urandom_range(0, 3) == 0) begin imem_read = 1; imem_address = $urandom; end
      if (!dmem_read && !dmem_write && $urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, 1);
        dmem_read = op; dmem_write = !op;
        dmem_address = $urandom; dmem_wdata = $urandom; dmem_byte_enable = $urandom;
      end
      if (busy != 1 && imem_read && $urandom_range(0, 7) == 0) imem_read = 0;
      if (busy != 2 && $urandom_range(0, 7) == 0) begin dmem_read = 0; dmem_write = 0; end
      if (busy == 1) imem_address = $urandom;
      if (busy == 2) begin dmem_address = $urandom; dmem_wdata = $urandom; dmem_byte_enable = $urandom; end
      mem_rdata = $urandom;
      mem_resp = (busy != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (mem_read !== (busy != 0 && e_rd) || mem_write !== (busy != 0 && e_wr)) begin
        errors++; $display("FAIL rand_cmd[%0d]: rd=%b wr=%b want %b/%b", cyc, mem_read, mem_write,
                           busy != 0 && e_rd, busy != 0 && e_wr);
      end
      if (busy != 0) begin
        checks++;
        if (mem_address !== e_addr || mem_byte_enable !== e_be || (e_wr && mem_wdata !== e_wd)) begin
          errors++; $display("FAIL rand_operands[%0d]: addr=%h be=%h wd=%h want %h/%h/%h", cyc,
                             mem_address, mem_byte_enable, mem_wdata, e_addr, e_be, e_wd);
        end
      end
      e_ir = (busy == 1) && mem_resp;
      e_dr = (busy == 2) && mem_resp;
      checks++;
      if (imem_resp !== e_ir || dmem_resp !== e_dr ||
          imem_rdata !== (e_ir ? mem_rdata : '0) || dmem_rdata !== ((e_dr && e_rd) ? mem_rdata : '0)) begin
        errors++; $display("FAIL rand_resp[%0d]: i=%b/%h d=%b/%h want %b/%h %b/%h", cyc,
                           imem_resp, imem_rdata, dmem_resp, dmem_rdata, e_ir, e_ir ? mem_rdata : '0,
                           e_dr, (e_dr && e_rd) ? mem_rdata : '0);
      end
      tick();
    end
    checks++;
    if (n_done < 20) begin errors++; $display("FAIL rand_activity: completed=%0d want >=20", n_done); end
    idle_inputs(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_i();
    test_d_write();
    test_contention();
    test_alternation();
    test_stray();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter between the pipelined RV32I datapath's I-mem and D-mem ports and the single downstream memory/cache port. It accepts one outstanding request per side, serialises them onto the downstream port, and returns data and a response pulse to the requesting side. It latches each granted request so the downstream command stays stable for the whole transaction. The pipeline registers may stall or advance without disturbing a transaction already in flight.

## Interface
- `ADDR_W`, default 32: address width, all ports.
- `DATA_W`, default 32: data width, all ports.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_read`  in  1  I-side read request.
- `imem_address`  in  ADDR_W  I-side address.
- `imem_rdata`  out  DATA_W  I-side read data; valid only while `imem_resp`=1.
- `imem_resp`  out  1  I-side completion pulse.
- `dmem_read`  in  1  D-side read request.
- `dmem_write`  in  1  D-side write request; never asserted together with `dmem_read`.
- `dmem_address`  in  ADDR_W  D-side address.
- `dmem_wdata`  in  DATA_W  D-side write data.
- `dmem_byte_enable`  in  DATA_W/8  D-side write byte enables.
- `dmem_rdata`  out  DATA_W  D-side read data; valid only while `dmem_resp`=1.
- `dmem_resp`  out  1  D-side completion pulse.
- `mem_read`  out  1  downstream read command.
- `mem_write`  out  1  downstream write command.
- `mem_address`  out  ADDR_W  downstream address.
- `mem_wdata`  out  DATA_W  downstream write data.
- `mem_byte_enable`  out  DATA_W/8  downstream byte enables; all ones on reads.
- `mem_rdata`  in  DATA_W  downstream read data.
- `mem_resp`  in  1  downstream completion, one cycle.

## Operation
- The FSM has three states: IDLE, SERVE_I, SERVE_D.
- **IDLE**
  - If any request is pending, grant one side.
  - Latch that side's address, wdata, byte enables and read/write type into the command register.
  - Go to SERVE_I or SERVE_D.
  - `mem_read` and `mem_write` are 0 in IDLE.
- **Grant priority, both sides pending in IDLE:** D wins (fixed priority; see Configuration).
- **SERVE_x**
  - `mem_read`, `mem_write`, `mem_address`, `mem_wdata` and `mem_byte_enable` are driven from the command register. They stay constant until `mem_resp`.
  - On `mem_resp`=1:
    - Assert `x_resp` combinationally in the same cycle.
    - Pass `mem_rdata` through to `x_rdata`.
    - Next state is IDLE.
- **Requester contract:** hold the request and its operands stable until its `resp` is seen.
  - The arbiter ignores input changes after the grant.
  - A request deasserted before grant is dropped with no response.
- **Non-granted side:**
  - Its `resp` stays 0.
  - Its `rdata` is 0.
  - Its request waits; there is no queueing beyond the requester holding it.
- **Writes:** `dmem_rdata` is 0 during the write response.
- **Response timing:** `mem_resp` arriving in IDLE is ignored. `imem_resp` and `dmem_resp` are never both 1 in the same cycle.
- **Reset** (asserted at any time, including mid-transaction):
  - FSM goes to IDLE and the command register is cleared.
  - All outputs go to 0 immediately.
  - The in-flight downstream transaction is abandoned; no response is issued for it.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE, and the last-grant register is D.
- **Request to command:** a request present at edge N (FSM in IDLE) gives `mem_read`/`mem_write` asserted from cycle N+1.
- **Command to response:** requester `resp` occurs in the same cycle as `mem_resp` (zero added latency).
- **Back-to-back:** one bubble cycle (IDLE) between consecutive transactions.
  - Minimum transaction = 2 cycles with `mem_resp` on the first SERVE cycle.
  - Peak throughput is one transaction per 2 cycles.
- **Simultaneous new request and response:** a request arriving in the `mem_resp` cycle is evaluated in the following IDLE cycle.
- **Starvation bound:**
  - Fixed priority: I waits indefinitely while D keeps requesting.
  - Round-robin: I waits at most one D transaction.

## Configuration
- Macro: `MEM_ARBITER_ROUND_ROBIN_EN`.
- **Defined:**
  - A 1-bit last-grant register updates on every grant.
  - When both sides are pending in IDLE, the side not granted last wins.
  - A single pending side is always granted.
- **Undefined:**
  - Fixed D-over-I priority.
  - The last-grant register is not instantiated.

## Test plan
- **Reset:**
  - Drive `rst`=1 mid-SERVE_D with `mem_read`=1.
  - Required: all outputs 0 in the same cycle.
  - Required: after release, `imem_read`=1 @0x100 gives `mem_read`=1, `mem_address`=0x100 the next cycle.
- **Single I read:**
  - Drive `imem_read` @0x40 and `mem_resp` two cycles after the command with `mem_rdata`=0xDEADBEEF.
  - Required: `imem_resp`=1 and `imem_rdata`=0xDEADBEEF for exactly one cycle; `dmem_resp` stays 0.
- **D write:**
  - Drive `dmem_write`, address 0x2002, `dmem_wdata`=0x0000AB00, `dmem_byte_enable`=0xC.
  - Required: `mem_write`=1 with identical address, wdata and enables, held stable even though the inputs are changed after the grant.
  - Required: `dmem_resp` pulses with `mem_resp`.
- **Contention, fixed priority:**
  - Drive I and D requests in the same cycle.
  - Required: D is served first, then one IDLE cycle, then I.
  - Required: `mem_read` never asserted during the IDLE cycle.
- **Contention, round-robin** (`MEM_ARBITER_ROUND_ROBIN_EN` defined):
  - Hold both requests continuously.
  - Required: grants alternate I, D, I, D after reset.
- **Stray response:**
  - Drive `mem_resp`=1 in IDLE.
  - Required: no requester `resp` and no state change.
